// File: rtl/eggtimer_ctrl.sv
// Egg timer control FSM: start/pause/clear sequencing, counter load/enable, timed alarm.
// Optional EGGTIMER_BEEP_EN: alarm toggles on each tick instead of staying steadily on.
module eggtimer_ctrl #(
   parameter int ALARM_SECONDS = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       start_btn,
   input  logic       clear_btn,
   input  logic       time_zero,
   output logic       load,
   output logic       count_en,
   output logic       alarm,
   output logic       running,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      ALARM = 3'd4,
      CLEAR = 3'd5
   } state_t;

   localparam logic [7:0] ALARM_MAX = 8'(ALARM_SECONDS);

   state_t     state_q, state_d;
   logic [7:0] alarm_cnt;
   logic       alarm_entry;

   assign alarm_entry = (state_q != ALARM) && (state_d == ALARM);

   // State, alarm tick counter and registered alarm drive all change on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         alarm_cnt <= 8'd0;
         alarm     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (alarm_entry)
            alarm_cnt <= 8'd0;
         else if (state_q == ALARM && tick && alarm_cnt < ALARM_MAX)
            alarm_cnt <= alarm_cnt + 8'd1;
`ifdef EGGTIMER_BEEP_EN
         if (state_d != ALARM || alarm_entry)
            alarm <= 1'b0;
         else if (tick)
            alarm <= ~alarm;
`else
         alarm <= (state_d == ALARM);
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (clear_btn)      state_d = CLEAR;
            else if (start_btn) state_d = LOAD;
         end
         LOAD:  state_d = RUN;
         RUN: begin
            if (time_zero)      state_d = ALARM;
            else if (clear_btn) state_d = CLEAR;
            else if (start_btn) state_d = PAUSE;
         end
         PAUSE: begin
            if (clear_btn)      state_d = CLEAR;
            else if (start_btn) state_d = RUN;
         end
         ALARM: begin
            if (clear_btn || start_btn || alarm_cnt == ALARM_MAX) state_d = CLEAR;
         end
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Gating with time_zero keeps the counters from ever wrapping below zero.
   always_comb begin
      load     = (state_q == LOAD) || (state_q == CLEAR);
      running  = (state_q == RUN);
      count_en = (state_q == RUN) && tick && !time_zero;
      state    = state_q;
   end

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Directed bench for eggtimer_ctrl with a small behavioural model of the digit counter chain.
module tb_eggtimer_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick, start_btn, clear_btn;
   logic       time_zero;
   logic       load, count_en, alarm, running;
   logic [2:0] state;

   logic [7:0] prog = 8'd0;
   logic [7:0] mcnt = 8'd0;
   int         n_vec = 0, n_bad = 0;
   int         ce_cnt = 0, ld_cnt = 0, ce0, ld0;

   eggtimer_ctrl #(.ALARM_SECONDS(5)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start_btn(start_btn),
      .clear_btn(clear_btn), .time_zero(time_zero), .load(load),
      .count_en(count_en), .alarm(alarm), .running(running), .state(state)
   );

   always #5 clk = ~clk;

   // Digit counter chain stand-in: load programmed time, decrement on count_en.
   always @(posedge clk) begin
      if (load) mcnt <= prog;
      else if (count_en && mcnt != 8'd0) mcnt <= mcnt - 8'd1;
   end
   assign time_zero = (mcnt == 8'd0);

   always @(posedge clk) begin
      if (count_en) ce_cnt <= ce_cnt + 1;
      if (load)     ld_cnt <= ld_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_once();
      repeat (4) cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; tick = 1'b0; start_btn = 1'b0; clear_btn = 1'b0;
      repeat (3) cyc();
      chk("rst_state", state, 0);
      chk("rst_load", load, 0);
      chk("rst_count_en", count_en, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_running", running, 0);
      #3 reset_n = 1'b1;
      cyc();

      // Normal countdown from 2, tick every 10 clocks
      prog = 8'd2;
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      chk("nrm_load_state", state, 1);
      chk("nrm_load_pulse", load, 1);
      cyc();
      chk("nrm_run_state", state, 2);
      chk("nrm_load_off", load, 0);
      chk("nrm_running", running, 1);
      for (int i = 0; i < 2; i++) begin
         repeat (9) cyc();
         tick = 1'b1; #1;
         chk("nrm_count_en", count_en, 1);
         cyc();
         tick = 1'b0;
      end
      chk("nrm_still_run", state, 2);
      cyc();
      chk("nrm_alarm_state", state, 4);
      chk("nrm_running_fall", running, 0);
`ifdef EGGTIMER_BEEP_EN
      chk("nrm_alarm_entry", alarm, 0);
`else
      chk("nrm_alarm_on", alarm, 1);
`endif
      chk("nrm_ce_count", ce_cnt, 2);
      chk("nrm_ld_count", ld_cnt, 1);

      // Alarm timeout after 5 ticks
      for (int i = 1; i <= 5; i++) begin
         repeat (9) cyc();
         tick = 1'b1; cyc(); tick = 1'b0;
         chk("to_in_alarm", state, 4);
`ifdef EGGTIMER_BEEP_EN
         chk("to_beep", alarm, 32'(i & 1));
`else
         chk("to_steady", alarm, 1);
`endif
      end
      cyc();
      chk("to_clear_state", state, 5);
      chk("to_clear_load", load, 1);
      cyc();
      chk("to_idle_state", state, 0);
      chk("to_idle_alarm", alarm, 0);
      chk("to_ld_count", ld_cnt, 2);

      // Pause / resume
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      cyc();
      chk("pr_run", state, 2);
      tick_once();
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      chk("pr_pause", state, 3);
      ce0 = ce_cnt;
      repeat (3) tick_once();
      chk("pr_no_ce", ce_cnt, ce0);
      chk("pr_held", state, 3);
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      chk("pr_resume", state, 2);
      tick_once();
      chk("pr_ce_resumed", ce_cnt, ce0 + 1);
      cyc();
      chk("pr_alarm", state, 4);
      clear_btn = 1'b1; cyc(); clear_btn = 1'b0;
      chk("pr_clear", state, 5);
      cyc();
      chk("pr_idle", state, 0);

      // Simultaneous buttons in RUN: clear wins
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      cyc();
      chk("sim_run", state, 2);
      ld0 = ld_cnt;
      start_btn = 1'b1; clear_btn = 1'b1; cyc();
      start_btn = 1'b0; clear_btn = 1'b0;
      chk("sim_clear", state, 5);
      chk("sim_load", load, 1);
      cyc();
      chk("sim_idle", state, 0);
      chk("sim_ld_once", ld_cnt, ld0 + 1);

      // Zero program: LOAD -> RUN -> ALARM, no count_en
      prog = 8'd0;
      ce0 = ce_cnt;
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      chk("zero_load", state, 1);
      cyc();
      chk("zero_run", state, 2);
      tick = 1'b1; #1;
      chk("zero_no_ce", count_en, 0);
      cyc();
      tick = 1'b0;
      chk("zero_alarm", state, 4);
      chk("zero_ce_total", ce_cnt, ce0);

      // Asynchronous reset mid-alarm
      tick_once();
      cyc(); cyc();
      chk("ra_pre_state", state, 4);
      chk("ra_pre_alarm", alarm, 1);
      #3 reset_n = 1'b0;
      #1;
      chk("ra_async_state", state, 0);
      chk("ra_async_alarm", alarm, 0);
      #10 reset_n = 1'b1;
      cyc();
      chk("ra_idle", state, 0);
      prog = 8'd3;
      start_btn = 1'b1; cyc(); start_btn = 1'b0;
      chk("ra_restart_load", state, 1);
      cyc();
      chk("ra_restart_run", running, 1);
      ce0 = ce_cnt;
      tick_once();
      chk("ra_restart_ce", ce_cnt, ce0 + 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
